// File: rtl/mem_req_ctrl_pkg.sv
// Shared defaults and sizing helpers for the memory request controller and its
// response FIFO.
package mem_req_ctrl_pkg;

  localparam int DEF_ADDR_WIDTH = 6;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_RSP_DEPTH  = 4;

  // Bits needed to index a buffer of 'depth' entries (at least one bit).
  function automatic int idx_bits(input int depth);
    if (depth > 1) begin
      return $clog2(depth);
    end else begin
      return 1;
    end
  endfunction

  // Bits needed to hold an occupancy count from 0 up to and including 'depth'.
  function automatic int cnt_bits(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/mem_rsp_fifo.sv
// Circular response FIFO with a registered head word. A word pushed on an edge
// shows up on 'head' only after that edge; there is no same-cycle bypass.
module mem_rsp_fifo
  import mem_req_ctrl_pkg::*;
#(
  parameter  int DEPTH = DEF_RSP_DEPTH,
  parameter  int WIDTH = DEF_DATA_WIDTH,
  localparam int PW    = idx_bits(DEPTH),
  localparam int CW    = cnt_bits(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);

  logic [WIDTH-1:0] store_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [PW-1:0]    rd_ptr_nxt_s;
  logic [CW-1:0]    count_r;
  logic [WIDTH-1:0] head_r;
  logic [WIDTH-1:0] head_nxt_s;

  // Pointer advance with explicit wrap so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == LAST_IDX) begin
      return {PW{1'b0}};
    end else begin
      return p + PW'(1);
    end
  endfunction

  // Work out which word sits at the head after this edge's pop/push.
  always_comb begin
    rd_ptr_nxt_s = rd_ptr_r;
    head_nxt_s   = {WIDTH{1'b0}};
    if (pop) begin
      rd_ptr_nxt_s = ptr_inc(rd_ptr_r);
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end
    // The write pointer only meets the new read pointer when the FIFO would
    // otherwise be empty, so the incoming word becomes the head directly.
    if (push && (wr_ptr_r == rd_ptr_nxt_s)) begin
      head_nxt_s = push_data;
    end else begin
      head_nxt_s = store_r[rd_ptr_nxt_s];
    end
  end

  // Storage array write; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      store_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers, occupancy and head register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
      head_r   <= {WIDTH{1'b0}};
    end else begin
      if (push) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      rd_ptr_r <= rd_ptr_nxt_s;
      head_r   <= head_nxt_s;
      case ({push, pop})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign head  = head_r;
  assign count = count_r;
  assign full  = (count_r == CW'(DEPTH));
  assign empty = (count_r == {CW{1'b0}});

  mem_rsp_fifo_chk u_chk (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: rtl/mem_rsp_fifo_chk.sv
// Property checker for the response FIFO: the credit scheme upstream must never
// push into a full FIFO, and the valid gating must never pop an empty one.
module mem_rsp_fifo_chk (
  input logic clk,
  input logic rst,
  input logic push,
  input logic pop,
  input logic full,
  input logic empty
);

  a_no_push_when_full: assert property (@(posedge clk) disable iff (rst) !(push && full));

  a_no_pop_when_empty: assert property (@(posedge clk) disable iff (rst) !(pop && empty));

endmodule

// File: rtl/mem_req_ctrl.sv
// Initiator-side controller for a single-port synchronous RAM with a one-cycle
// registered read. Requests pass straight through to the RAM port; read data
// returns in order through a credit-limited response FIFO.
module mem_req_ctrl
  import mem_req_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int RSP_DEPTH  = DEF_RSP_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  input  logic [DATA_WIDTH-1:0] mem_out,
  output logic                  busy
);

  localparam int CW = cnt_bits(RSP_DEPTH);

  logic                  inflight_r;
  logic [CW-1:0]         fifo_count_s;
  logic                  fifo_full_s;
  logic                  fifo_empty_s;
  logic [DATA_WIDTH-1:0] fifo_head_s;
  logic [CW:0]           credit_used_s;
  logic                  ready_s;
  logic                  rd_fire_s;
  logic                  rsp_valid_s;
  logic                  pop_s;

  // Credit and handshake decode. Readiness depends only on registered state
  // (plus reset), so there is no path from req_valid or rsp_ready into it.
  always_comb begin
    credit_used_s = {1'b0, fifo_count_s} + {{CW{1'b0}}, inflight_r};
    if (rst) begin
      ready_s = 1'b0;
    end else begin
      ready_s = (credit_used_s < (CW + 1)'(RSP_DEPTH)) && !fifo_full_s;
    end
    rd_fire_s   = req_valid && ready_s && !req_we;
    rsp_valid_s = !rst && !fifo_empty_s;
    pop_s       = rsp_valid_s && rsp_ready;
  end

  // RAM drive and client-facing outputs; all quiet while reset is held.
  always_comb begin
    mem_addr  = req_addr;
    mem_data  = req_data;
    mem_we    = req_valid && ready_s && req_we;
    req_ready = ready_s;
    rsp_valid = rsp_valid_s;
    if (rst) begin
      rsp_data = {DATA_WIDTH{1'b0}};
      busy     = 1'b0;
    end else begin
      rsp_data = fifo_head_s;
      busy     = inflight_r || !fifo_empty_s;
    end
  end

  // A read accepted this cycle has its data on mem_out during the next one.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_r <= 1'b0;
    end else begin
      inflight_r <= rd_fire_s;
    end
  end

  mem_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_r),
    .push_data (mem_out),
    .pop       (pop_s),
    .head      (fifo_head_s),
    .count     (fifo_count_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

endmodule
